id_ex_stage: RTL

//  Decode-to-execute pipeline stage; consumes the register file read ports (Data1/Data2) and the decoded

---
 rtl/mips_pipe_pkg.sv | 40 ++++
 rtl/load_use_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: control-word bit positions,
// instruction field slices, stage FSM states and the immediate extender.
package mips_pipe_pkg;

  localparam int CTRL_W = 12;

  localparam int C_REG_WRITE  = 0;
  localparam int C_MEM_READ   = 1;
  localparam int C_MEM_WRITE  = 2;
  localparam int C_ZERO_EXT   = 3;
  localparam int C_USES_RS    = 4;
  localparam int C_USES_RT    = 5;
  localparam int C_ALU_SRC    = 6;
  localparam int C_BRANCH     = 7;
  localparam int C_JUMP       = 8;
  localparam int C_ALU_OP_LSB = 9;

  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_BUBBLE = 1'b1
  } stage_state_e;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic zero_ext);
    return zero_ext ? {16'b0, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check: a load sitting in ID/EX whose destination is read
// by the instruction currently in decode.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic     ex_valid,
  input  logic     ex_mem_read,
  input  reg_idx_t ex_rt,
  input  logic     id_valid,
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  input  logic     id_uses_rs,
  input  logic     id_uses_rt,
  output logic     hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);

  // Register 0 never carries a real dependency, so a load into $0 is ignored.
  assign hazard = ex_valid && ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                  (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, write-back bypass into decode,
// flush, downstream hold and a saturating stall-cycle counter.
module id_ex_stage #(
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_pc4,
  input  logic [31:0]       rf_data1,
  input  logic [31:0]       rf_data2,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [31:0]       wb_write_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [31:0]       ex_pc4,
  output logic [CNT_W-1:0]  stall_count
);

  import mips_pipe_pkg::*;

  reg_idx_t     id_rs;
  reg_idx_t     id_rt;
  reg_idx_t     id_rd;
  reg_idx_t     id_shamt;
  logic [15:0]  id_imm;
  logic         unused_opcode;
  logic [31:0]  rs_fwd;
  logic [31:0]  rt_fwd;
  logic [31:0]  imm_ext;
  logic         hazard_raw;
  logic         hazard;
  stage_state_e state;

  assign id_rs         = id_instr[RS_MSB:RS_LSB];
  assign id_rt         = id_instr[RT_MSB:RT_LSB];
  assign id_rd         = id_instr[RD_MSB:RD_LSB];
  assign id_shamt      = id_instr[SHAMT_MSB:SHAMT_LSB];
  assign id_imm        = id_instr[IMM_MSB:IMM_LSB];
  assign unused_opcode = ^id_instr[31:26];

  // Write-back result is not yet visible in the register file read data.
  assign rs_fwd = (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_rs))
                  ? wb_write_data : rf_data1;
  assign rt_fwd = (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_rt))
                  ? wb_write_data : rf_data2;

  assign imm_ext = extend_imm(id_imm, id_ctrl[C_ZERO_EXT]);

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[C_MEM_READ]),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_ctrl[C_USES_RS]),
    .id_uses_rt  (id_ctrl[C_USES_RT]),
    .hazard      (hazard_raw)
  );

  // The bubble cycle already has ex_valid=0; gating on RUN keeps the one-bubble rule explicit.
  assign hazard = hazard_raw && (state == S_RUN);
  assign stall  = rst_n && !flush && (ex_hold || hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_pc4     <= '0;
    end else if (flush) begin
      state      <= S_RUN;
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_pc4     <= '0;
    end else if (ex_hold) begin
      state <= state;
    end else if (hazard) begin
      state      <= S_BUBBLE;
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_pc4     <= '0;
    end else begin
      state      <= S_RUN;
      ex_valid   <= id_valid;
      ex_ctrl    <= id_valid ? id_ctrl : '0;
      ex_rs_data <= rs_fwd;
      ex_rt_data <= rt_fwd;
      ex_imm     <= imm_ext;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_shamt   <= id_shamt;
      ex_pc4     <= id_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
